regfile_port_ctrl: RTL and testbench
====================================

Name: regfile_port_ctrl

Overview:
- Controller in front of the 32x32 register file. Owns its single write port and borrows read port A.
- After reset, and on request, it sequences a hardware clear of x1..x(WORDS-1).
- Arbitrates the write port between core writeback (priority) and a debug/monitor port.
- Services debug reads by time-sharing source-A select when the core is not reading.

Parameters:
- DATA_WIDTH, 32, register width
- WORDS, 32, number of registers
- SELECT_SIZE, 5, register select width (2^SELECT_SIZE = WORDS)

Ports:
- clk_i  in  1  clock; all state updates on posedge
- reset_i  in  1  async active-high reset
- clear_i  in  1  pulse: re-run clear sequence (honoured only in IDLE)
- ready_o  out  1  high when core writes and reads are accepted (not clearing)
- core_we_i  in  1  core writeback request, active high, single-cycle
- core_dst_i  in  SELECT_SIZE  core destination register
- core_data_i  in  DATA_WIDTH  core write data
- core_rd_en_i  in  1  core is using read port A this cycle
- core_srcA_i  in  SELECT_SIZE  core source-A select
- dbg_req_i  in  1  debug request; held until dbg_ack_o
- dbg_we_i  in  1  1=write, 0=read
- dbg_addr_i  in  SELECT_SIZE  debug register select
- dbg_wdata_i  in  DATA_WIDTH  debug write data
- dbg_ack_o  out  1  one-cycle completion pulse
- dbg_rdata_o  out  DATA_WIDTH  read data; valid with dbg_ack_o, held until the next read ack
- drop_o  out  1  sticky: core_we_i seen while ready_o low; cleared only by reset
- rf_we_o  out  1  register file write enable, active low
- rf_dst_o  out  SELECT_SIZE  register file destination select
- rf_data_o  out  DATA_WIDTH  register file write data
- rf_srcA_o  out  SELECT_SIZE  register file source-A select
- rf_srcA_data_i  in  DATA_WIDTH  register file source-A output

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state=CLEAR, idx=1, ready_o=0, rf_we_o=1, rf_dst_o=0, rf_data_o=0
  - dbg_ack_o=0, dbg_rdata_o=0, drop_o=0
- Write timing:
  - rf_we_o, rf_dst_o and rf_data_o are registered on posedge.
  - The register file commits on the following negedge.
  - A write is therefore visible on a read port by the next posedge.
- rf_srcA_o is combinational:
  - dbg_addr_i in state DBG_RD.
  - core_srcA_i otherwise.
- CLEAR state:
  - Each cycle drive rf_we_o=0, rf_dst_o=idx, rf_data_o=0, then idx++.
  - After writing idx=WORDS-1, rf_we_o returns to 1 next cycle and the state goes to IDLE.
  - Takes exactly WORDS-1 write cycles; ready_o=1 from the first IDLE cycle.
  - core_we_i in CLEAR is ignored and sets drop_o.
  - dbg_req_i is held off: no ack.
- IDLE, evaluated each posedge with priority:
  1. clear_i: go to CLEAR with idx=1. A simultaneous core_we_i is still written this cycle, before the clear.
  2. core_we_i: rf_we_o=0, dst and data from core, next cycle. If core_dst_i==0, rf_we_o stays 1 (no write).
  3. dbg_req_i & dbg_we_i: go to DBG_WR.
  4. dbg_req_i & ~dbg_we_i & ~core_rd_en_i: go to DBG_RD.
  5. Otherwise rf_we_o=1.
- DBG_WR, one cycle:
  - Drive rf_we_o=0 (1 if dbg_addr_i==0), dst=dbg_addr_i, data=dbg_wdata_i.
  - Pulse dbg_ack_o, return to IDLE.
  - If core_we_i arrives in DBG_WR, the core wins: the core write is issued, DBG_WR is retried the next cycle, and no ack is given.
- DBG_RD, one cycle:
  - rf_srcA_o=dbg_addr_i; capture rf_srcA_data_i into dbg_rdata_o.
  - Pulse dbg_ack_o, return to IDLE.
  - Core writes are still accepted in DBG_RD.
- dbg_req_i must be low (or a new request) in the cycle after the ack. A request still high is treated as a new transaction.
- Reset mid-sequence aborts any transaction with no ack. The clear restarts at idx=1 on reset release.
- ready_o=0 in CLEAR only.

Test Plan:
- Reset release -> rf_we_o low for 31 consecutive cycles with rf_dst_o=1..31 and rf_data_o=0. ready_o rises on cycle 32. Read of x31 returns 0.
- IDLE, core_we_i with dst=5, data=0xDEADBEEF -> next cycle rf_we_o=0, rf_dst_o=5. A debug read of x5 then acks with dbg_rdata_o=0xDEADBEEF.
- Simultaneous core_we_i (dst=3) and dbg write (addr=3, data=0x11) -> core write first. Debug write the following cycle with ack. Final x3=0x11.
- Debug read of x7 while core_rd_en_i=1 for 4 cycles -> no ack, rf_srcA_o=core_srcA_i. Ack 2 cycles after core_rd_en_i falls, with correct data.
- core_we_i or debug write to x0 -> rf_we_o stays 1 and the debug ack still pulses. core_we_i during CLEAR -> drop_o=1 and stays set.
- Reset asserted mid-DBG_RD and mid-CLEAR (idx=12) -> outputs return to reset values immediately, no ack, and the clear restarts at idx=1.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
// Write-port owner and read-port-A arbiter for the 32x32 register file.
// Sequences the x1..x(WORDS-1) hardware clear and services debug accesses.
module regfile_port_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int WORDS       = 32,
    parameter int SELECT_SIZE = 5
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    output logic                   ready_o,
    input  logic                   core_we_i,
    input  logic [SELECT_SIZE-1:0] core_dst_i,
    input  logic [DATA_WIDTH-1:0]  core_data_i,
    input  logic                   core_rd_en_i,
    input  logic [SELECT_SIZE-1:0] core_srcA_i,
    input  logic                   dbg_req_i,
    input  logic                   dbg_we_i,
    input  logic [SELECT_SIZE-1:0] dbg_addr_i,
    input  logic [DATA_WIDTH-1:0]  dbg_wdata_i,
    output logic                   dbg_ack_o,
    output logic [DATA_WIDTH-1:0]  dbg_rdata_o,
    output logic                   drop_o,
    output logic                   rf_we_o,
    output logic [SELECT_SIZE-1:0] rf_dst_o,
    output logic [DATA_WIDTH-1:0]  rf_data_o,
    output logic [SELECT_SIZE-1:0] rf_srcA_o,
    input  logic [DATA_WIDTH-1:0]  rf_srcA_data_i
);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        DBG_WR,
        DBG_RD
    } state_t;

    // One extra bit so the counter can reach WORDS and mark the end.
    localparam logic [SELECT_SIZE:0] IDX_END = WORDS[SELECT_SIZE:0];
    localparam logic [SELECT_SIZE:0] IDX_ONE = {{SELECT_SIZE{1'b0}}, 1'b1};

    state_t               state;
    logic [SELECT_SIZE:0] idx;

    assign rf_srcA_o = (state == DBG_RD) ? dbg_addr_i : core_srcA_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= CLEAR;
            idx         <= IDX_ONE;
            ready_o     <= 1'b0;
            rf_we_o     <= 1'b1;
            rf_dst_o    <= '0;
            rf_data_o   <= '0;
            dbg_ack_o   <= 1'b0;
            dbg_rdata_o <= '0;
            drop_o      <= 1'b0;
        end else begin
            dbg_ack_o <= 1'b0;
            rf_we_o   <= 1'b1;
            if (core_we_i && !ready_o) begin
                drop_o <= 1'b1;
            end
            unique case (state)
                CLEAR: begin
                    if (idx == IDX_END) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                    end else begin
                        rf_we_o   <= 1'b0;
                        rf_dst_o  <= idx[SELECT_SIZE-1:0];
                        rf_data_o <= '0;
                        idx       <= idx + 1'b1;
                    end
                end
                IDLE: begin
                    if (core_we_i) begin
                        rf_we_o   <= (core_dst_i == '0);
                        rf_dst_o  <= core_dst_i;
                        rf_data_o <= core_data_i;
                    end
                    if (clear_i) begin
                        state   <= CLEAR;
                        idx     <= IDX_ONE;
                        ready_o <= 1'b0;
                    end else if (core_we_i) begin
                        state <= IDLE;
                    end else if (dbg_req_i && dbg_we_i) begin
                        state <= DBG_WR;
                    end else if (dbg_req_i && !core_rd_en_i) begin
                        state <= DBG_RD;
                    end
                end
                DBG_WR: begin
                    // Core writeback takes the port; the debug write retries.
                    if (core_we_i) begin
                        rf_we_o   <= (core_dst_i == '0);
                        rf_dst_o  <= core_dst_i;
                        rf_data_o <= core_data_i;
                    end else begin
                        rf_we_o   <= (dbg_addr_i == '0);
                        rf_dst_o  <= dbg_addr_i;
                        rf_data_o <= dbg_wdata_i;
                        dbg_ack_o <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DBG_RD: begin
                    if (core_we_i) begin
                        rf_we_o   <= (core_dst_i == '0);
                        rf_dst_o  <= core_dst_i;
                        rf_data_o <= core_data_i;
                    end
                    dbg_rdata_o <= rf_srcA_data_i;
                    dbg_ack_o   <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a behavioural register file.
module tb_regfile_port_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        ready_o;
    logic        core_we_i = 1'b0;
    logic [4:0]  core_dst_i = '0;
    logic [31:0] core_data_i = '0;
    logic        core_rd_en_i = 1'b0;
    logic [4:0]  core_srcA_i = '0;
    logic        dbg_req_i = 1'b0;
    logic        dbg_we_i = 1'b0;
    logic [4:0]  dbg_addr_i = '0;
    logic [31:0] dbg_wdata_i = '0;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;
    logic        drop_o;
    logic        rf_we_o;
    logic [4:0]  rf_dst_o;
    logic [31:0] rf_data_o;
    logic [4:0]  rf_srcA_o;
    logic [31:0] rf_srcA_data_i;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [32];
    logic        mem_init = 1'b0;

    regfile_port_ctrl dut (
        .clk_i(clk_i), .reset_i(reset_i), .clear_i(clear_i),
        .ready_o(ready_o), .core_we_i(core_we_i),
        .core_dst_i(core_dst_i), .core_data_i(core_data_i),
        .core_rd_en_i(core_rd_en_i), .core_srcA_i(core_srcA_i),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i),
        .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
        .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
        .drop_o(drop_o), .rf_we_o(rf_we_o), .rf_dst_o(rf_dst_o),
        .rf_data_o(rf_data_o), .rf_srcA_o(rf_srcA_o),
        .rf_srcA_data_i(rf_srcA_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Register file: powers up with junk, commits on negedge, x0 reads zero.
    always @(negedge clk_i) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 + i;
            mem_init <= 1'b1;
        end else if (!rf_we_o && rf_dst_o != 5'd0) begin
            mem[rf_dst_o] <= rf_data_o;
        end
    end

    assign rf_srcA_data_i = (rf_srcA_o == 5'd0) ? 32'd0 : mem[rf_srcA_o];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic dbg_txn(input logic we, input logic [4:0] addr,
                           input logic [31:0] wdata, output int cyc,
                           output logic [31:0] rd);
        dbg_req_i = 1'b1;
        dbg_we_i = we;
        dbg_addr_i = addr;
        dbg_wdata_i = wdata;
        cyc = -1;
        rd = '0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (dbg_ack_o) begin
                cyc = i;
                rd = dbg_rdata_o;
                break;
            end
        end
        dbg_req_i = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        tests++;
        if ({ready_o, rf_we_o, rf_dst_o, rf_data_o} !== {1'b0, 1'b1, 5'd0, 32'd0}) begin
            fails++;
            $display("FAIL reset_rf: ready=%b we=%b dst=%0d data=%h, want 0 1 0 0",
                     ready_o, rf_we_o, rf_dst_o, rf_data_o);
        end
        tests++;
        if ({dbg_ack_o, dbg_rdata_o, drop_o} !== {1'b0, 32'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_dbg: ack=%b rdata=%h drop=%b, want 0 0 0",
                     dbg_ack_o, dbg_rdata_o, drop_o);
        end
        reset_i = 1'b0;
    endtask

    task automatic test_clear_seq();
        int cyc;
        logic [31:0] rd;
        for (int n = 1; n <= 31; n++) begin
            step();
            tests++;
            if ({ready_o, rf_we_o, rf_dst_o, rf_data_o} !== {1'b0, 1'b0, n[4:0], 32'd0}) begin
                fails++;
                $display("FAIL clear_cycle%0d: ready=%b we=%b dst=%0d data=%h, want 0 0 %0d 0",
                         n, ready_o, rf_we_o, rf_dst_o, rf_data_o, n);
            end
        end
        step();
        tests++;
        if ({ready_o, rf_we_o} !== 2'b11) begin
            fails++;
            $display("FAIL clear_done: ready=%b we=%b, want 1 1", ready_o, rf_we_o);
        end
        dbg_txn(1'b0, 5'd31, 32'd0, cyc, rd);
        tests++;
        if (cyc !== 2 || rd !== 32'd0) begin
            fails++;
            $display("FAIL clear_read_x31: cycles=%0d data=%h, want 2 0", cyc, rd);
        end
    endtask

    task automatic test_core_write();
        int cyc;
        logic [31:0] rd;
        core_we_i = 1'b1;
        core_dst_i = 5'd5;
        core_data_i = 32'hDEAD_BEEF;
        step();
        core_we_i = 1'b0;
        tests++;
        if ({rf_we_o, rf_dst_o, rf_data_o} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
            fails++;
            $display("FAIL core_write: we=%b dst=%0d data=%h, want 0 5 deadbeef",
                     rf_we_o, rf_dst_o, rf_data_o);
        end
        step();
        tests++;
        if (rf_we_o !== 1'b1) begin
            fails++;
            $display("FAIL core_write_release: we=%b, want 1", rf_we_o);
        end
        dbg_txn(1'b0, 5'd5, 32'd0, cyc, rd);
        tests++;
        if (cyc !== 2 || rd !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL core_write_readback: cycles=%0d data=%h, want 2 deadbeef", cyc, rd);
        end
    endtask

    task automatic test_collision();
        int cyc;
        logic [31:0] rd;
        core_we_i = 1'b1;
        core_dst_i = 5'd3;
        core_data_i = 32'h22;
        dbg_req_i = 1'b1;
        dbg_we_i = 1'b1;
        dbg_addr_i = 5'd3;
        dbg_wdata_i = 32'h11;
        step();
        core_we_i = 1'b0;
        tests++;
        if ({rf_we_o, rf_dst_o, rf_data_o, dbg_ack_o} !== {1'b0, 5'd3, 32'h22, 1'b0}) begin
            fails++;
            $display("FAIL collide_core_first: we=%b dst=%0d data=%h ack=%b, want 0 3 22 0",
                     rf_we_o, rf_dst_o, rf_data_o, dbg_ack_o);
        end
        step();
        tests++;
        if ({rf_we_o, dbg_ack_o} !== 2'b10) begin
            fails++;
            $display("FAIL collide_gap: we=%b ack=%b, want 1 0", rf_we_o, dbg_ack_o);
        end
        step();
        dbg_req_i = 1'b0;
        tests++;
        if ({rf_we_o, rf_dst_o, rf_data_o, dbg_ack_o} !== {1'b0, 5'd3, 32'h11, 1'b1}) begin
            fails++;
            $display("FAIL collide_dbg_write: we=%b dst=%0d data=%h ack=%b, want 0 3 11 1",
                     rf_we_o, rf_dst_o, rf_data_o, dbg_ack_o);
        end
        step();
        dbg_txn(1'b0, 5'd3, 32'd0, cyc, rd);
        tests++;
        if (cyc !== 2 || rd !== 32'h11) begin
            fails++;
            $display("FAIL collide_final_x3: cycles=%0d data=%h, want 2 11", cyc, rd);
        end
    endtask

    task automatic test_core_wins_dbg_wr();
        dbg_req_i = 1'b1;
        dbg_we_i = 1'b1;
        dbg_addr_i = 5'd9;
        dbg_wdata_i = 32'h99;
        step();
        core_we_i = 1'b1;
        core_dst_i = 5'd10;
        core_data_i = 32'hAA;
        step();
        core_we_i = 1'b0;
        tests++;
        if ({rf_we_o, rf_dst_o, rf_data_o, dbg_ack_o} !== {1'b0, 5'd10, 32'hAA, 1'b0}) begin
            fails++;
            $display("FAIL dbgwr_core_wins: we=%b dst=%0d data=%h ack=%b, want 0 10 aa 0",
                     rf_we_o, rf_dst_o, rf_data_o, dbg_ack_o);
        end
        step();
        dbg_req_i = 1'b0;
        tests++;
        if ({rf_we_o, rf_dst_o, rf_data_o, dbg_ack_o} !== {1'b0, 5'd9, 32'h99, 1'b1}) begin
            fails++;
            $display("FAIL dbgwr_retry: we=%b dst=%0d data=%h ack=%b, want 0 9 99 1",
                     rf_we_o, rf_dst_o, rf_data_o, dbg_ack_o);
        end
        step();
    endtask

    task automatic test_read_blocked();
        int cyc;
        logic [31:0] rd;
        dbg_txn(1'b1, 5'd7, 32'h7777, cyc, rd);
        tests++;
        if (cyc !== 2) begin
            fails++;
            $display("FAIL blocked_setup_x7: cycles=%0d, want 2", cyc);
        end
        step();
        core_rd_en_i = 1'b1;
        core_srcA_i = 5'd4;
        dbg_req_i = 1'b1;
        dbg_we_i = 1'b0;
        dbg_addr_i = 5'd7;
        for (int n = 1; n <= 4; n++) begin
            step();
            tests++;
            if (dbg_ack_o !== 1'b0 || rf_srcA_o !== 5'd4) begin
                fails++;
                $display("FAIL blocked_cycle%0d: ack=%b srcA=%0d, want 0 4",
                         n, dbg_ack_o, rf_srcA_o);
            end
        end
        core_rd_en_i = 1'b0;
        step();
        tests++;
        if (dbg_ack_o !== 1'b0 || rf_srcA_o !== 5'd7) begin
            fails++;
            $display("FAIL blocked_dbg_rd: ack=%b srcA=%0d, want 0 7", dbg_ack_o, rf_srcA_o);
        end
        step();
        dbg_req_i = 1'b0;
        tests++;
        if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== 32'h7777) begin
            fails++;
            $display("FAIL blocked_ack: ack=%b data=%h, want 1 7777", dbg_ack_o, dbg_rdata_o);
        end
        step();
        tests++;
        if (dbg_ack_o !== 1'b0 || dbg_rdata_o !== 32'h7777) begin
            fails++;
            $display("FAIL blocked_hold: ack=%b data=%h, want 0 7777", dbg_ack_o, dbg_rdata_o);
        end
    endtask

    task automatic test_x0();
        int cyc;
        logic [31:0] rd;
        core_we_i = 1'b1;
        core_dst_i = 5'd0;
        core_data_i = 32'h55;
        step();
        core_we_i = 1'b0;
        tests++;
        if (rf_we_o !== 1'b1) begin
            fails++;
            $display("FAIL core_x0: we=%b, want 1", rf_we_o);
        end
        dbg_txn(1'b1, 5'd0, 32'h66, cyc, rd);
        tests++;
        if (cyc !== 2 || rf_we_o !== 1'b1) begin
            fails++;
            $display("FAIL dbg_x0: cycles=%0d we=%b, want 2 1", cyc, rf_we_o);
        end
        step();
    endtask

    task automatic test_drop();
        int cyc;
        logic [31:0] rd;
        int wait_n;
        tests++;
        if (drop_o !== 1'b0) begin
            fails++;
            $display("FAIL drop_initial: drop=%b, want 0", drop_o);
        end
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        tests++;
        if (ready_o !== 1'b0) begin
            fails++;
            $display("FAIL reclear_ready: ready=%b, want 0", ready_o);
        end
        core_we_i = 1'b1;
        core_dst_i = 5'd6;
        core_data_i = 32'h6666;
        step();
        core_we_i = 1'b0;
        tests++;
        if ({drop_o, rf_we_o, rf_dst_o, rf_data_o} !== {1'b1, 1'b0, 5'd1, 32'd0}) begin
            fails++;
            $display("FAIL drop_set: drop=%b we=%b dst=%0d data=%h, want 1 0 1 0",
                     drop_o, rf_we_o, rf_dst_o, rf_data_o);
        end
        wait_n = 0;
        while (!ready_o && wait_n < 40) begin
            step();
            wait_n++;
        end
        tests++;
        if (wait_n !== 31 || drop_o !== 1'b1) begin
            fails++;
            $display("FAIL reclear_done: cycles=%0d drop=%b, want 31 1", wait_n, drop_o);
        end
        dbg_txn(1'b0, 5'd6, 32'd0, cyc, rd);
        tests++;
        if (cyc !== 2 || rd !== 32'd0) begin
            fails++;
            $display("FAIL drop_x6: cycles=%0d data=%h, want 2 0", cyc, rd);
        end
        step();
        dbg_txn(1'b0, 5'd5, 32'd0, cyc, rd);
        tests++;
        if (cyc !== 2 || rd !== 32'd0) begin
            fails++;
            $display("FAIL reclear_x5: cycles=%0d data=%h, want 2 0", cyc, rd);
        end
        step();
    endtask

    task automatic test_reset_abort();
        int wait_n;
        dbg_req_i = 1'b1;
        dbg_we_i = 1'b0;
        dbg_addr_i = 5'd3;
        step();
        tests++;
        if (rf_srcA_o !== 5'd3) begin
            fails++;
            $display("FAIL abort_in_rd: srcA=%0d, want 3", rf_srcA_o);
        end
        reset_i = 1'b1;
        #1;
        tests++;
        if ({ready_o, rf_we_o, rf_dst_o, dbg_ack_o, dbg_rdata_o, drop_o} !==
            {1'b0, 1'b1, 5'd0, 1'b0, 32'd0, 1'b0}) begin
            fails++;
            $display("FAIL abort_rd_reset: ready=%b we=%b dst=%0d ack=%b rdata=%h drop=%b",
                     ready_o, rf_we_o, rf_dst_o, dbg_ack_o, dbg_rdata_o, drop_o);
        end
        dbg_req_i = 1'b0;
        step();
        reset_i = 1'b0;
        for (int n = 1; n <= 12; n++) step();
        tests++;
        if ({rf_we_o, rf_dst_o} !== {1'b0, 5'd12}) begin
            fails++;
            $display("FAIL abort_clear_reach12: we=%b dst=%0d, want 0 12", rf_we_o, rf_dst_o);
        end
        reset_i = 1'b1;
        #1;
        tests++;
        if ({ready_o, rf_we_o, rf_dst_o, rf_data_o} !== {1'b0, 1'b1, 5'd0, 32'd0}) begin
            fails++;
            $display("FAIL abort_clear_reset: ready=%b we=%b dst=%0d data=%h, want 0 1 0 0",
                     ready_o, rf_we_o, rf_dst_o, rf_data_o);
        end
        step();
        reset_i = 1'b0;
        step();
        tests++;
        if ({rf_we_o, rf_dst_o} !== {1'b0, 5'd1}) begin
            fails++;
            $display("FAIL abort_restart: we=%b dst=%0d, want 0 1", rf_we_o, rf_dst_o);
        end
        wait_n = 0;
        while (!ready_o && wait_n < 40) begin
            step();
            wait_n++;
        end
        tests++;
        if (wait_n !== 31) begin
            fails++;
            $display("FAIL abort_finish: cycles=%0d, want 31", wait_n);
        end
    endtask

    initial begin
        test_reset();
        test_clear_seq();
        test_core_write();
        test_collision();
        test_core_wins_dbg_wr();
        test_read_blocked();
        test_x0();
        test_drop();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
